// File: rtl/bsg_dff_reset_rr_arb_pkg.sv
// ----------------------------------------------------------------------------
// | bsg_dff_reset_rr_arb_pkg : shared defaults and tag-width helper           |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

package bsg_dff_reset_rr_arb_pkg;

   localparam int DEFAULT_WIDTH_P = 128;
   localparam int DEFAULT_ELS_P   = 4;

   function automatic int tag_width(input int els);
      return (els > 2) ? $clog2(els) : 1;
   endfunction

endpackage

`default_nettype wire

// File: rtl/bsg_dff_reset_rr_arb_if.sv
// ----------------------------------------------------------------------------
// | bsg_dff_reset_rr_arb_if : requester and downstream handshake bundle       |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

interface bsg_dff_reset_rr_arb_if
   import bsg_dff_reset_rr_arb_pkg::*;
#(
   parameter int width_p = DEFAULT_WIDTH_P,
   parameter int els_p   = DEFAULT_ELS_P
);
   localparam int tag_w_lp = tag_width(els_p);

   logic [els_p-1:0]         v_i;
   logic [els_p*width_p-1:0] data_i;
   logic [els_p-1:0]         yumi_o;
   logic                     v_o;
   logic [width_p-1:0]       data_o;
   logic [tag_w_lp-1:0]      tag_o;
   logic                     ready_i;

   modport master (
      output v_i, data_i, ready_i,
      input  yumi_o, v_o, data_o, tag_o
   );

   modport slave (
      input  v_i, data_i, ready_i,
      output yumi_o, v_o, data_o, tag_o
   );

endinterface

`default_nettype wire

// File: rtl/bsg_rr_arb_grant.sv
// ----------------------------------------------------------------------------
// | bsg_rr_arb_grant : round-robin grant with last_grant state                |
// | Optional macro: BSG_DFF_RESET_RR_ARB_LOCK_EN (adds lock_i)                |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_rr_arb_grant
   import bsg_dff_reset_rr_arb_pkg::*;
#(
   parameter  int els_p    = DEFAULT_ELS_P,
   localparam int tag_w_lp = tag_width(els_p)
) (
   input  wire logic                clk_i,
   input  wire logic                reset_i,
   input  wire logic                en_i,
`ifdef BSG_DFF_RESET_RR_ARB_LOCK_EN
   input  wire logic                lock_i,
`endif
   input  wire logic [els_p-1:0]    req_i,
   output logic      [els_p-1:0]    grant_o,
   output logic      [tag_w_lp-1:0] grant_idx_o
);

   logic [tag_w_lp-1:0] last_grant_q, last_grant_d;
   logic [els_p-1:0]    eligible;
   logic                hit;

`ifdef BSG_DFF_RESET_RR_ARB_LOCK_EN
   logic granted_once_q, granted_once_d;

   // Lock only pins arbitration once there is a real previous winner.
   always_comb begin
      eligible = req_i;
      if (lock_i && granted_once_q)
         eligible = req_i & (els_p'(1) << last_grant_q);
   end

   assign granted_once_d = granted_once_q | hit;

   always_ff @(posedge clk_i) begin
      if (reset_i) granted_once_q <= 1'b0;
      else         granted_once_q <= granted_once_d;
   end
`else
   assign eligible = req_i;
`endif

   always_comb begin
      int idx;
      idx         = 0;
      hit         = 1'b0;
      grant_o     = '0;
      grant_idx_o = '0;
      for (int i = 1; i <= els_p; i++) begin
         idx = int'(last_grant_q) + i;
         if (idx >= els_p) idx = idx - els_p;
         if (!hit && en_i && eligible[idx]) begin
            hit          = 1'b1;
            grant_o[idx] = 1'b1;
            grant_idx_o  = tag_w_lp'(idx);
         end
      end
   end

   assign last_grant_d = hit ? grant_idx_o : last_grant_q;

   // Reset to els_p-1 so requester 0 is searched first.
   always_ff @(posedge clk_i) begin
      if (reset_i) last_grant_q <= tag_w_lp'(els_p - 1);
      else         last_grant_q <= last_grant_d;
   end

endmodule

`default_nettype wire

// File: rtl/bsg_dff_reset_rr_arb.sv
// ----------------------------------------------------------------------------
// | bsg_dff_reset_rr_arb : round-robin arbiter into a one-entry output reg    |
// | Optional macro: BSG_DFF_RESET_RR_ARB_LOCK_EN (adds lock_i)                |
// | Revision: 1.0                                                             |
// ----------------------------------------------------------------------------
`default_nettype none

module bsg_dff_reset_rr_arb
   import bsg_dff_reset_rr_arb_pkg::*;
#(
   parameter  int width_p  = DEFAULT_WIDTH_P,
   parameter  int els_p    = DEFAULT_ELS_P,
   localparam int tag_w_lp = tag_width(els_p)
) (
   input  wire logic               clk_i,
   input  wire logic               reset_i,
`ifdef BSG_DFF_RESET_RR_ARB_LOCK_EN
   input  wire logic               lock_i,
`endif
   bsg_dff_reset_rr_arb_if.slave   io
);

   logic                v_q, v_d;
   logic [width_p-1:0]  data_q, data_d;
   logic [tag_w_lp-1:0] tag_q, tag_d;
   logic [tag_w_lp-1:0] grant_idx;
   logic [els_p-1:0]    grant;
   logic                slot_free;
   logic                load;

   // The |v_i term of the load enable is folded into "some grant occurred".
   assign slot_free = (~v_q | io.ready_i) & ~reset_i;
   assign load      = |grant;

   bsg_rr_arb_grant #(.els_p(els_p)) u_grant (
      .clk_i       (clk_i),
      .reset_i     (reset_i),
      .en_i        (slot_free),
`ifdef BSG_DFF_RESET_RR_ARB_LOCK_EN
      .lock_i      (lock_i),
`endif
      .req_i       (io.v_i),
      .grant_o     (grant),
      .grant_idx_o (grant_idx)
   );

   always_comb begin
      v_d    = v_q;
      data_d = data_q;
      tag_d  = tag_q;
      if (load) begin
         v_d    = 1'b1;
         data_d = io.data_i[int'(grant_idx)*width_p +: width_p];
         tag_d  = grant_idx;
      end else if (io.ready_i) begin
         v_d    = 1'b0;
      end
   end

   always_ff @(posedge clk_i) begin
      if (reset_i) begin
         v_q    <= 1'b0;
         data_q <= '0;
         tag_q  <= '0;
      end else begin
         v_q    <= v_d;
         data_q <= data_d;
         tag_q  <= tag_d;
      end
   end

   assign io.yumi_o = grant;
   assign io.v_o    = v_q;
   assign io.data_o = data_q;
   assign io.tag_o  = tag_q;

endmodule

`default_nettype wire

// File: doc/bsg_dff_reset_rr_arb.md
BSG_DFF_RESET_RR_ARB -- requirements
Module: bsg_dff_reset_rr_arb

Interface
REQ-001 Parameter: width_p, default 128, payload width in bits per requester.
REQ-002 Parameter: els_p, default 4, number of requesters; legal range 2..16.
REQ-003 Port: clk_i  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: reset_i  input  1  reset, synchronous and active-high.
REQ-005 Port: v_i  input  els_p  per-requester valid.
REQ-006 Port: data_i  input  els_p*width_p  per-requester payload; requester k occupies bits [k*width_p +: width_p].
REQ-007 Port: yumi_o  output  els_p  one-hot grant; requester k's payload is consumed this cycle.
REQ-008 Port: v_o  output  1  output register holds valid data.
REQ-009 Port: data_o  output  width_p  registered payload of the last winner.
REQ-010 Port: tag_o  output  max(1,$clog2(els_p))  index of the requester whose payload is in data_o.
REQ-011 Port: ready_i  input  1  downstream accepts data_o when v_o & ready_i.

Function
REQ-012 The output register shall be one entry, loaded only on a grant.
REQ-013 Load enable: (~v_o | ready_i) & (|v_i) & ~reset_i.
REQ-014 When load enable is high, the block shall assert exactly one yumi_o bit, combinationally in the same cycle.
REQ-015 On the next edge, data_o, tag_o and v_o=1 shall hold the granted payload and index; latency is 1 cycle.
REQ-016 Priority shall be round-robin: search starts at last_grant+1 (mod els_p) and wraps to index 0 after els_p-1.
REQ-017 last_grant shall update only on an actual grant.
REQ-018 Drain without refill (v_o & ready_i & ~|v_i): v_o shall go to 0; data_o and tag_o shall keep their last values.
REQ-019 Simultaneous drain and grant shall give back-to-back transfer, one per cycle, with no bubble.
REQ-020 When v_o=1 and ready_i=0, yumi_o shall be all-zero and data_o/tag_o shall be stable.
REQ-021 yumi_o shall never be asserted for a requester whose v_i is 0.

Reset
REQ-022 While reset_i=1, yumi_o shall be 0 combinationally.
REQ-023 On the edge with reset_i=1: v_o=0, data_o=0, tag_o=0, last_grant=els_p-1, so requester 0 has first priority after reset.
REQ-024 Reset asserted with v_o=1 shall discard the held payload with no handshake.

Configuration
REQ-025 Macro BSG_DFF_RESET_RR_ARB_LOCK_EN defined: an input port lock_i (1 bit) shall be added.
REQ-026 With the macro, while lock_i=1 and at least one grant has occurred since reset, only requester last_grant is eligible and the others shall wait (multi-beat packets).
REQ-027 With the macro, lock_i shall be ignored until the first grant after reset.
REQ-028 Macro undefined: no lock_i port, and arbitration is pure round-robin per REQ-016.

Structure
REQ-029 Package bsg_dff_reset_rr_arb_pkg shall hold the default width (128), default els (4) and a tag-width function max(1,$clog2(els)).
REQ-030 Sub-module bsg_rr_arb_grant shall contain the last_grant register, the rotate-priority search and the lock qualification.
REQ-031 The top level shall contain the output register and the handshake logic only.

Verification
REQ-032 Reset, then v_i=4'b1111, ready_i=1 held: yumi_o sequence 0001,0010,0100,1000,0001; tag_o 0,1,2,3,0 one cycle later.
REQ-033 v_i=4'b0100 with data 128'hA5..A5, ready_i=0: one grant, v_o=1, data_o=A5..A5, tag_o=2; yumi_o=0 for the next 5 cycles; ready_i=1 then causes a drain plus a new grant in the same cycle.
REQ-034 After granting 3, v_i=4'b1001: next grant is 0 (wrap-around), then 3.
REQ-035 Reset pulse while v_o=1 and v_i=4'b1111: yumi_o=0 during reset; after reset v_o=0, then the first grant goes to requester 0.
REQ-036 LOCK_EN build: grant 1, then hold lock_i=1 with v_i=4'b1111 for 4 cycles: yumi_o=0010 every cycle; on lock_i=0 the next grant is 2.
REQ-037 Idle drain: v_o=1, v_i=0, ready_i=1: v_o goes to 0 next cycle with data_o unchanged.
